// File: rtl/pwm_motor_ctrl_pkg.sv
// Shared constants and state encoding for the multi-channel motor PWM block.
package pwm_motor_ctrl_pkg;

    localparam int CH_N_DFLT         = 2;
    localparam int DUTY_W_DFLT       = 8;
    localparam int PRESC_W_DFLT      = 16;
    localparam int RAMP_STEP_DFLT    = 4;
    localparam int DEAD_PERIODS_DFLT = 2;

    // state      | meaning
    // ST_RUN     | applied duty slews toward the target duty
    // ST_BRAKE   | reversal requested, applied duty slews down to zero
    // ST_DEAD    | bridge held low for whole periods before the direction flips
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BRAKE = 2'd1,
        ST_DEAD  = 2'd2
    } ch_state_e;

    localparam logic high_p = 1'b1;
    localparam logic low_p  = 1'b0;

endpackage

// File: rtl/pwm_motor_ctrl_channel.sv
// One motor channel: target registers, ramp/brake/dead-time FSM and output flops.
// state    | meaning
// ST_RUN   | cur ramps toward tgt_duty by at most RAMP_STEP per period
// ST_BRAKE | cur ramps down to zero before a reversal
// ST_DEAD  | output forced low, dcnt counts whole periods, then Dir_o flips
module pwm_motor_ctrl_channel
    import pwm_motor_ctrl_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DFLT,
    parameter int RAMP_STEP    = RAMP_STEP_DFLT,
    parameter int DEAD_PERIODS = DEAD_PERIODS_DFLT
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              Enable_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic              boundary_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              dir_i,
    input  logic              load_i,
    output logic              pwm_o,
    output logic              dir_o,
    output logic              busy_o
);

    localparam int DCNT_W = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);
    localparam logic [DUTY_W:0]   STEP_W    = (DUTY_W+1)'(RAMP_STEP);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEAD_PERIODS - 1);

    ch_state_e         state_q, state_d;
    logic [DUTY_W-1:0] cur_q, cur_d, tgt_duty_q, tgt_duty_d;
    logic              tgt_dir_q, tgt_dir_d, dir_q, dir_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              pwm_q, pwm_d, busy_q, busy_d;

    logic [DUTY_W:0]   cur_w, tgt_w, gap_w, ramp_w, brake_w, ramp_nxt_w, brake_nxt_w;
    logic              ramp_up;

    // Target capture, one-boundary-per-step slewing, reversal sequencing and outputs.
    always_comb begin
        tgt_duty_d = load_i ? duty_i : tgt_duty_q;
        tgt_dir_d  = load_i ? dir_i  : tgt_dir_q;
        state_d    = state_q;
        cur_d      = cur_q;
        dir_d      = dir_q;
        dcnt_d     = dcnt_q;

        cur_w       = {1'b0, cur_q};
        tgt_w       = {1'b0, tgt_duty_q};
        ramp_up     = tgt_w > cur_w;
        gap_w       = ramp_up ? (tgt_w - cur_w) : (cur_w - tgt_w);
        ramp_w      = (gap_w < STEP_W) ? gap_w : STEP_W;
        brake_w     = (cur_w < STEP_W) ? cur_w : STEP_W;
        ramp_nxt_w  = ramp_up ? (cur_w + ramp_w) : (cur_w - ramp_w);
        brake_nxt_w = cur_w - brake_w;

        if (!Enable_i) begin
            // Bridge undriven: direction tracks the command so re-enable needs no dead-time.
            state_d = ST_RUN;
            cur_d   = '0;
            dcnt_d  = '0;
            dir_d   = tgt_dir_d;
        end else if (boundary_i) begin
            // The step taken at a boundary always uses the pre-load target.
            case (state_q)
                ST_RUN: begin
                    if (tgt_dir_q == dir_q) begin
                        cur_d = ramp_nxt_w[DUTY_W] ? '1 : ramp_nxt_w[DUTY_W-1:0];
                    end else if (cur_q == '0) begin
                        state_d = ST_DEAD;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_BRAKE;
                    end
                end
                ST_BRAKE: begin
                    if (tgt_dir_q == dir_q) begin
                        state_d = ST_RUN;
                    end else begin
                        cur_d = brake_nxt_w[DUTY_W-1:0];
                        if (brake_nxt_w == '0) begin
                            state_d = ST_DEAD;
                            dcnt_d  = '0;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dcnt_q == DCNT_LAST) begin
                        dir_d   = tgt_dir_q;
                        state_d = ST_RUN;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        pwm_d  = (Enable_i && (cnt_i < cur_q) && (state_q != ST_DEAD)) ? high_p : low_p;
        busy_d = (state_d != ST_RUN) || (cur_d != tgt_duty_d);
    end

    // Channel state register.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q    <= ST_RUN;
            cur_q      <= '0;
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b0;
            dir_q      <= 1'b0;
            dcnt_q     <= '0;
            pwm_q      <= low_p;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            dir_q      <= dir_d;
            dcnt_q     <= dcnt_d;
            pwm_q      <= pwm_d;
            busy_q     <= busy_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign dir_o  = dir_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel motor PWM top: shared prescaler, period counter and wrap pulse.
module pwm_motor_ctrl
    import pwm_motor_ctrl_pkg::*;
#(
    parameter int CH_N         = CH_N_DFLT,
    parameter int DUTY_W       = DUTY_W_DFLT,
    parameter int PRESC_W      = PRESC_W_DFLT,
    parameter int RAMP_STEP    = RAMP_STEP_DFLT,
    parameter int DEAD_PERIODS = DEAD_PERIODS_DFLT
) (
    input  logic                   Clk_i,
    input  logic                   Reset_i,
    input  logic                   Enable_i,
    input  logic [PRESC_W-1:0]     Prescale_i,
    input  logic [CH_N*DUTY_W-1:0] Duty_i,
    input  logic [CH_N-1:0]        Dir_i,
    input  logic [CH_N-1:0]        Load_i,
    output logic [CH_N-1:0]        Pwm_o,
    output logic [CH_N-1:0]        Dir_o,
    output logic [CH_N-1:0]        Busy_o,
    output logic                   Period_o
);

    // Counter runs 0..2^DUTY_W-2 so a full-scale duty stays high all period.
    localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  cnt_q, cnt_d;
    logic               period_q, period_d;
    logic               tick, boundary;

    // Prescaler and period counter; >= keeps the prescaler bounded if Prescale_i shrinks.
    always_comb begin
        presc_d  = '0;
        cnt_d    = '0;
        period_d = low_p;
        tick     = 1'b0;
        boundary = 1'b0;
        if (Enable_i) begin
            tick     = (presc_q >= Prescale_i);
            boundary = tick && (cnt_q == CNT_MAX);
            presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
            cnt_d    = cnt_q;
            if (tick) begin
                cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + DUTY_W'(1);
            end
            period_d = boundary;
        end
    end

    // Shared timing registers.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            period_q <= low_p;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign Period_o = period_q;

    for (genvar k = 0; k < CH_N; k++) begin : gen_ch
        pwm_motor_ctrl_channel #(
            .DUTY_W       (DUTY_W),
            .RAMP_STEP    (RAMP_STEP),
            .DEAD_PERIODS (DEAD_PERIODS)
        ) u_ch (
            .Clk_i      (Clk_i),
            .Reset_i    (Reset_i),
            .Enable_i   (Enable_i),
            .cnt_i      (cnt_q),
            .boundary_i (boundary),
            .duty_i     (Duty_i[k*DUTY_W +: DUTY_W]),
            .dir_i      (Dir_i[k]),
            .load_i     (Load_i[k]),
            .pwm_o      (Pwm_o[k]),
            .dir_o      (Dir_o[k]),
            .busy_o     (Busy_o[k])
        );
    end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Bench for pwm_motor_ctrl: directed scenarios plus random commands against a period-level model.
module tb_pwm_motor_ctrl;

    localparam int CH_N    = 2;
    localparam int DUTY_W  = 8;
    localparam int PRESC_W = 16;
    localparam int RAMP    = 4;
    localparam int DEADP   = 2;
    localparam int PER     = 255;

    localparam int M_RUN   = 0;
    localparam int M_BRAKE = 1;
    localparam int M_DEAD  = 2;

    logic                   Clk_i = 1'b0;
    logic                   Reset_i;
    logic                   Enable_i;
    logic [PRESC_W-1:0]     Prescale_i;
    logic [CH_N*DUTY_W-1:0] Duty_i;
    logic [CH_N-1:0]        Dir_i, Load_i;
    logic [CH_N-1:0]        Pwm_o, Dir_o, Busy_o;
    logic                   Period_o;

    always #5 Clk_i = ~Clk_i;

    pwm_motor_ctrl #(
        .CH_N(CH_N), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W),
        .RAMP_STEP(RAMP), .DEAD_PERIODS(DEADP)
    ) dut (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .Enable_i(Enable_i), .Prescale_i(Prescale_i),
        .Duty_i(Duty_i), .Dir_i(Dir_i), .Load_i(Load_i),
        .Pwm_o(Pwm_o), .Dir_o(Dir_o), .Busy_o(Busy_o), .Period_o(Period_o)
    );

    int errors = 0;
    int checks = 0;

    // reference model: per-channel applied duty, target, direction and mode
    int m_cur[CH_N], m_tgt[CH_N], m_mode[CH_N], m_dcnt[CH_N];
    bit m_tdir[CH_N], m_dir[CH_N], m_pwm[CH_N];
    bit m_period;
    int m_n;

    // measurements taken from the DUT outputs
    int hi[CH_N], last_hi[CH_N];
    int cyc = 0, last_per = -1, spacing = 0;
    logic [CH_N-1:0] prev_dir = '0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH_N; k++) begin
            m_cur[k] = 0; m_tgt[k] = 0; m_mode[k] = M_RUN; m_dcnt[k] = 0;
            m_tdir[k] = 0; m_dir[k] = 0; m_pwm[k] = 0;
        end
        m_period = 0;
        m_n = 0;
    endtask

    // One PWM-period decision for channel k, from the channel rules.
    task automatic advance(input int k);
        case (m_mode[k])
            M_RUN: begin
                if (m_tdir[k] == m_dir[k]) begin
                    if (m_cur[k] < m_tgt[k]) m_cur[k] += imin(RAMP, m_tgt[k] - m_cur[k]);
                    else                     m_cur[k] -= imin(RAMP, m_cur[k] - m_tgt[k]);
                end else if (m_cur[k] == 0) begin
                    m_mode[k] = M_DEAD; m_dcnt[k] = 0;
                end else begin
                    m_mode[k] = M_BRAKE;
                end
            end
            M_BRAKE: begin
                if (m_tdir[k] == m_dir[k]) m_mode[k] = M_RUN;
                else begin
                    m_cur[k] -= imin(RAMP, m_cur[k]);
                    if (m_cur[k] == 0) begin m_mode[k] = M_DEAD; m_dcnt[k] = 0; end
                end
            end
            default: begin
                m_dcnt[k]++;
                if (m_dcnt[k] == DEADP) begin m_dir[k] = m_tdir[k]; m_mode[k] = M_RUN; end
            end
        endcase
    endtask

    // Model of one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int p, cnt;
        bit bnd;
        if (!Reset_i) begin
            model_reset();
        end else if (!Enable_i) begin
            m_n = 0;
            m_period = 0;
            for (int k = 0; k < CH_N; k++) begin
                m_pwm[k] = 0; m_cur[k] = 0; m_mode[k] = M_RUN; m_dcnt[k] = 0;
                if (Load_i[k]) begin m_tgt[k] = int'(Duty_i[k*DUTY_W +: DUTY_W]); m_tdir[k] = Dir_i[k]; end
                m_dir[k] = m_tdir[k];
            end
        end else begin
            p   = int'(Prescale_i) + 1;
            bnd = ((m_n + 1) % (p * PER)) == 0;
            cnt = (m_n / p) % PER;
            for (int k = 0; k < CH_N; k++) begin
                m_pwm[k] = (cnt < m_cur[k]) && (m_mode[k] != M_DEAD);
                if (bnd) advance(k);
                if (Load_i[k]) begin m_tgt[k] = int'(Duty_i[k*DUTY_W +: DUTY_W]); m_tdir[k] = Dir_i[k]; end
            end
            m_period = bnd;
            m_n++;
        end
    endtask

    task automatic cycle();
        logic [CH_N-1:0] ep, ed, eb;
        @(posedge Clk_i);
        model_edge();
        #1;
        for (int k = 0; k < CH_N; k++) begin
            ep[k] = m_pwm[k];
            ed[k] = m_dir[k];
            eb[k] = (m_mode[k] != M_RUN) || (m_cur[k] != m_tgt[k]);
        end
        check("pwm",    32'(Pwm_o),    32'(ep));
        check("dir",    32'(Dir_o),    32'(ed));
        check("busy",   32'(Busy_o),   32'(eb));
        check("period", 32'(Period_o), 32'(m_period));
        if (Dir_o != prev_dir) check("pwm_at_dir_flip", 32'(Pwm_o & (Dir_o ^ prev_dir)), 32'd0);
        prev_dir = Dir_o;
        cyc++;
        for (int k = 0; k < CH_N; k++) hi[k] += int'(Pwm_o[k]);
        if (Period_o) begin
            for (int k = 0; k < CH_N; k++) begin last_hi[k] = hi[k]; hi[k] = 0; end
            if (last_per >= 0) spacing = cyc - last_per;
            last_per = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [CH_N-1:0] mask, input int d0, input int d1, input logic [CH_N-1:0] dirs);
        Load_i = mask;
        Duty_i = {8'(d1), 8'(d0)};
        Dir_i  = dirs;
        cycle();
        Load_i = '0;
    endtask

    initial begin
        Reset_i = 1'b1; Enable_i = 1'b0; Prescale_i = '0;
        Duty_i = '0; Dir_i = '0; Load_i = '0;
        for (int k = 0; k < CH_N; k++) begin hi[k] = 0; last_hi[k] = 0; end
        model_reset();
        #1 Reset_i = 1'b0;
        #1;
        check("rst_pwm", 32'(Pwm_o), 32'd0);
        check("rst_dir", 32'(Dir_o), 32'd0);
        check("rst_busy", 32'(Busy_o), 32'd0);
        check("rst_period", 32'(Period_o), 32'd0);
        run(2);
        Reset_i = 1'b1;

        // ch0 ramp to 16, ch1 long ramp to full scale
        Enable_i = 1'b1;
        load(2'b11, 16, 255, 2'b00);
        run(5*PER);
        check("ramp16_hi", 32'(last_hi[0]), 32'd16);
        check("ramp16_busy", 32'(Busy_o[0]), 32'd0);

        // down to 8, then reversal with brake and dead-time
        load(2'b01, 8, 255, 2'b00);
        run(3*PER);
        check("duty8_hi", 32'(last_hi[0]), 32'd8);
        load(2'b01, 8, 255, 2'b01);
        run(8*PER);
        check("rev_dir", 32'(Dir_o[0]), 32'd1);
        check("rev_hi", 32'(last_hi[0]), 32'd8);
        check("rev_busy", 32'(Busy_o[0]), 32'd0);

        // ch1 at full scale, then back to zero
        run(52*PER);
        check("full_hi", 32'(last_hi[1]), 32'd255);
        check("full_busy", 32'(Busy_o[1]), 32'd0);
        check("period_255", 32'(spacing), 32'd255);
        load(2'b10, 8, 0, 2'b01);
        run(66*PER);
        check("zero_hi", 32'(last_hi[1]), 32'd0);
        check("zero_busy", 32'(Busy_o[1]), 32'd0);

        // prescale 3
        Enable_i = 1'b0;
        cycle();
        Prescale_i = 16'd3;
        Enable_i = 1'b1;
        run(3*4*PER + 5);
        check("period_1020", 32'(spacing), 32'd1020);

        // reset in the middle of a ramp
        Enable_i = 1'b0;
        Prescale_i = '0;
        load(2'b01, 16, 0, 2'b00);
        Enable_i = 1'b1;
        run(2*PER + 10);
        #3 Reset_i = 1'b0;
        model_reset();
        #1;
        check("async_pwm", 32'(Pwm_o), 32'd0);
        check("async_dir", 32'(Dir_o), 32'd0);
        check("async_busy", 32'(Busy_o), 32'd0);
        check("async_period", 32'(Period_o), 32'd0);
        cycle();
        Reset_i = 1'b1;
        run(3*PER + 5);
        check("post_rst_hi", 32'(last_hi[0]), 32'd0);
        check("post_rst_busy", 32'(Busy_o), 32'd0);

        // disable while running, reverse while disabled
        load(2'b01, 12, 0, 2'b00);
        run(4*PER + 10);
        check("en_hi12", 32'(last_hi[0]), 32'd12);
        Enable_i = 1'b0;
        load(2'b01, 12, 0, 2'b01);
        check("dis_pwm", 32'(Pwm_o[0]), 32'd0);
        check("dis_dir", 32'(Dir_o[0]), 32'd1);
        run(3);
        Enable_i = 1'b1;
        run(5*PER + 5);
        check("reen_hi", 32'(last_hi[0]), 32'd12);
        check("reen_dir", 32'(Dir_o[0]), 32'd1);
        check("reen_busy", 32'(Busy_o[0]), 32'd0);

        // random commands
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                Enable_i = 1'b0;
                run($urandom_range(1, 5));
                Prescale_i = 16'($urandom_range(0, 1));
                Enable_i = 1'b1;
            end
            Load_i = 2'($urandom_range(1, 3));
            Duty_i = 16'($urandom);
            Dir_i  = 2'($urandom);
            cycle();
            Load_i = '0;
            run($urandom_range(50, 500));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
